// File: rtl/line_window_buffer_if.sv
// Pixel stream in, vertical tap column out, for line_window_buffer.
// Latency: n/a (signal bundle only).
// Backpressure: none; the source pushes one pixel per cycle with fsync & rsync high.
// Ports: fsync/rsync/pdata_in (source -> buffer); taps_out/tap_valid/col_out/lines_ready/overflow (buffer -> sink).
interface line_window_buffer_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int NO_OF_COLS  = 320,
    parameter int NO_OF_LINES = 3
);
    localparam int CW = $clog2(NO_OF_COLS);

    logic                              fsync;
    logic                              rsync;
    logic [DATA_WIDTH-1:0]             pdata_in;
    logic [NO_OF_LINES*DATA_WIDTH-1:0] taps_out;
    logic                              tap_valid;
    logic [CW-1:0]                     col_out;
    logic                              lines_ready;
    logic                              overflow;

    modport master (
        output fsync, rsync, pdata_in,
        input  taps_out, tap_valid, col_out, lines_ready, overflow
    );

    modport slave (
        input  fsync, rsync, pdata_in,
        output taps_out, tap_valid, col_out, lines_ready, overflow
    );
endinterface

// File: rtl/line_window_buffer.sv
// Line buffer producing NO_OF_LINES vertical taps per accepted pixel (current pixel plus the lines above).
// Latency: 1 clk from accept (fsync & rsync) to taps_out/col_out/tap_valid.
// Backpressure: none; pixels past NO_OF_COLS in one line are dropped and flag the sticky overflow.
// Ports: clk, rst_n (async active-low); bus (slave modport) carries the pixel stream and tap outputs.
module line_window_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int NO_OF_COLS  = 320,
    parameter int NO_OF_LINES = 3,
    parameter int BORDER_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    line_window_buffer_if.slave  bus
);
    localparam int CW = $clog2(NO_OF_COLS);
    localparam int LW = $clog2(NO_OF_COLS + 1);
    localparam int NW = $clog2(NO_OF_LINES);
    localparam int NS = NO_OF_LINES - 1;

    localparam logic [CW-1:0] COL_MAX  = CW'(NO_OF_COLS - 1);
    localparam logic [LW-1:0] COLS_LEN = LW'(NO_OF_COLS);
    localparam logic [NW-1:0] LINE_MAX = NW'(NO_OF_LINES - 1);

    // Stored lines: mem_q[j-1] is line j above the incoming one.
    logic [DATA_WIDTH-1:0] mem_q [NS][NO_OF_COLS];

    logic [CW-1:0]  col_q;
    logic           full_q;      // column NO_OF_COLS-1 already taken this line
    logic [NW-1:0]  line_q;
    logic           rsync_q;
    // minlen_q[k-1] = shortest length among the k lines above. Tap k at column c
    // is only meaningful if every line between it and the current one reached c,
    // otherwise the vertical shift at c skipped a line and the data is misaligned.
    logic [LW-1:0]  minlen_q [NS];
    logic [LW-1:0]  minlen_d [NS];

    logic [NO_OF_LINES*DATA_WIDTH-1:0] taps_q;
    logic [NO_OF_LINES*DATA_WIDTH-1:0] taps_d;
    logic                              tap_vld_q;
    logic [CW-1:0]                     col_out_q;
    logic                              overflow_q;

    logic                  accept;
    logic                  wr_en;
    logic                  drop;
    logic                  line_end;
    logic [LW-1:0]         cur_len;
    logic [DATA_WIDTH-1:0] edge_val;

    assign accept   = bus.fsync & bus.rsync;
    assign wr_en    = accept & ~full_q;
    assign drop     = accept & full_q;
    assign line_end = bus.fsync & rsync_q & ~bus.rsync;
    assign cur_len  = full_q ? COLS_LEN : LW'(col_q);

    // Read-before-write tap assembly; edge_val tracks the highest filled tap
    // so replicate mode can copy it into the unfilled ones above.
    always_comb begin
        taps_d                   = '0;
        edge_val                 = bus.pdata_in;
        taps_d[DATA_WIDTH-1:0]   = bus.pdata_in;
        for (int k = 1; k < NO_OF_LINES; k++) begin
            if (LW'(col_q) < minlen_q[k-1]) begin
                edge_val                               = mem_q[k-1][col_q];
                taps_d[k*DATA_WIDTH +: DATA_WIDTH]     = mem_q[k-1][col_q];
            end else if (BORDER_MODE != 0) begin
                taps_d[k*DATA_WIDTH +: DATA_WIDTH]     = edge_val;
            end
        end
    end

    always_comb begin
        for (int j = 0; j < NS; j++) begin
            minlen_d[j] = '0;
        end
        minlen_d[0] = cur_len;
        for (int j = 1; j < NS; j++) begin
            minlen_d[j] = (minlen_q[j-1] < cur_len) ? minlen_q[j-1] : cur_len;
        end
    end

    // Line storage has no reset; stale contents are masked by minlen_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[0][col_q] <= bus.pdata_in;
            for (int j = 1; j < NS; j++) begin
                mem_q[j][col_q] <= mem_q[j-1][col_q];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            full_q     <= 1'b0;
            line_q     <= '0;
            rsync_q    <= 1'b0;
            for (int j = 0; j < NS; j++) begin
                minlen_q[j] <= '0;
            end
            taps_q     <= '0;
            tap_vld_q  <= 1'b0;
            col_out_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (!bus.fsync) begin
                // Frame gap or abort: position state restarts, a partial line is not counted.
                col_q   <= '0;
                full_q  <= 1'b0;
                line_q  <= '0;
                rsync_q <= 1'b0;
                for (int j = 0; j < NS; j++) begin
                    minlen_q[j] <= '0;
                end
            end else begin
                rsync_q <= bus.rsync;
                if (line_end) begin
                    col_q  <= '0;
                    full_q <= 1'b0;
                    if (line_q != LINE_MAX) begin
                        line_q <= line_q + 1'b1;
                    end
                    for (int j = 0; j < NS; j++) begin
                        minlen_q[j] <= minlen_d[j];
                    end
                end else if (wr_en) begin
                    if (col_q == COL_MAX) begin
                        full_q <= 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
            end

            tap_vld_q <= wr_en;
            if (wr_en) begin
                taps_q    <= taps_d;
                col_out_q <= col_q;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.taps_out    = taps_q;
    assign bus.tap_valid   = tap_vld_q;
    assign bus.col_out     = col_out_q;
    assign bus.lines_ready = (line_q == LINE_MAX);
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_line_window_buffer.sv
// Directed bench for line_window_buffer: two instances (zero and replicate border) share one stimulus.
// Latency: expectations sampled on the falling edge after the accepting rising edge.
// Backpressure: none to model; overflow and frame-abort sequences are in the vector table.
module tb_line_window_buffer;
    localparam int DW = 8;
    localparam int NC = 4;
    localparam int NL = 3;

    typedef struct {
        bit fs;
        bit rs;
        int pd;
        bit vld;
        int col;
        int t0;
        int t1z;
        int t2z;
        int t1r;
        int t2r;
        bit rdy;
        bit ovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        fs;
    logic        rs;
    logic [7:0]  pd;

    int   checks;
    int   errors;
    vec_t tv[$];

    line_window_buffer_if #(.DATA_WIDTH(DW), .NO_OF_COLS(NC), .NO_OF_LINES(NL)) if0 ();
    line_window_buffer_if #(.DATA_WIDTH(DW), .NO_OF_COLS(NC), .NO_OF_LINES(NL)) if1 ();

    assign if0.fsync    = fs;
    assign if0.rsync    = rs;
    assign if0.pdata_in = pd;
    assign if1.fsync    = fs;
    assign if1.rsync    = rs;
    assign if1.pdata_in = pd;

    line_window_buffer #(.DATA_WIDTH(DW), .NO_OF_COLS(NC), .NO_OF_LINES(NL), .BORDER_MODE(0)) u0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0)
    );

    line_window_buffer #(.DATA_WIDTH(DW), .NO_OF_COLS(NC), .NO_OF_LINES(NL), .BORDER_MODE(1)) u1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] tap(input logic [NL*DW-1:0] t, input int k);
        return {24'd0, t[k*DW +: DW]};
    endfunction

    task automatic add(input bit fs_i, input bit rs_i, input int pd_i,
                       input bit vld, input int col, input int t0,
                       input int t1z, input int t2z, input int t1r, input int t2r,
                       input bit rdy, input bit ovf);
        vec_t v;
        v.fs = fs_i; v.rs = rs_i; v.pd = pd_i;
        v.vld = vld; v.col = col; v.t0 = t0;
        v.t1z = t1z; v.t2z = t2z; v.t1r = t1r; v.t2r = t2r;
        v.rdy = rdy; v.ovf = ovf;
        tv.push_back(v);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " taps bm0"}, {8'd0, if0.taps_out}, 32'd0);
        chk({tag, " taps bm1"}, {8'd0, if1.taps_out}, 32'd0);
        chk({tag, " vld"},      {31'd0, if0.tap_valid | if1.tap_valid}, 32'd0);
        chk({tag, " col"},      {30'd0, if0.col_out | if1.col_out}, 32'd0);
        chk({tag, " rdy"},      {31'd0, if0.lines_ready | if1.lines_ready}, 32'd0);
        chk({tag, " ovf"},      {31'd0, if0.overflow | if1.overflow}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        fs     = 1'b0;
        rs     = 1'b0;
        pd     = '0;

        //  fs rs pd    vld col t0  t1z t2z t1r t2r rdy ovf
        add(0, 0, 0,    0, 0, 0,  0,  0,  0,  0,  0, 0);
        // line 0: first pixel 7, then 1..3
        add(1, 1, 7,    1, 0, 7,  0,  0,  7,  7,  0, 0);
        add(1, 1, 1,    1, 1, 1,  0,  0,  1,  1,  0, 0);
        add(1, 1, 2,    1, 2, 2,  0,  0,  2,  2,  0, 0);
        add(1, 1, 3,    1, 3, 3,  0,  0,  3,  3,  0, 0);
        add(1, 0, 0,    0, 0, 0,  0,  0,  0,  0,  0, 0);
        // line 1
        add(1, 1, 10,   1, 0, 10, 7,  0,  7,  7,  0, 0);
        add(1, 1, 11,   1, 1, 11, 1,  0,  1,  1,  0, 0);
        add(1, 1, 12,   1, 2, 12, 2,  0,  2,  2,  0, 0);
        add(1, 1, 13,   1, 3, 13, 3,  0,  3,  3,  0, 0);
        add(1, 0, 0,    0, 0, 0,  0,  0,  0,  0,  1, 0);
        // line 2: six accepts, last two dropped
        add(1, 1, 20,   1, 0, 20, 10, 7,  10, 7,  1, 0);
        add(1, 1, 21,   1, 1, 21, 11, 1,  11, 1,  1, 0);
        add(1, 1, 22,   1, 2, 22, 12, 2,  12, 2,  1, 0);
        add(1, 1, 23,   1, 3, 23, 13, 3,  13, 3,  1, 0);
        add(1, 1, 24,   0, 0, 0,  0,  0,  0,  0,  1, 1);
        add(1, 1, 25,   0, 0, 0,  0,  0,  0,  0,  1, 1);
        add(1, 0, 0,    0, 0, 0,  0,  0,  0,  0,  1, 1);
        // line 3: short, two pixels
        add(1, 1, 30,   1, 0, 30, 20, 10, 20, 10, 1, 1);
        add(1, 1, 31,   1, 1, 31, 21, 11, 21, 11, 1, 1);
        add(1, 0, 0,    0, 0, 0,  0,  0,  0,  0,  1, 1);
        // line 4: columns 2,3 lie beyond the short line above
        add(1, 1, 40,   1, 0, 40, 30, 20, 30, 20, 1, 1);
        add(1, 1, 41,   1, 1, 41, 31, 21, 31, 21, 1, 1);
        add(1, 1, 42,   1, 2, 42, 0,  0,  42, 42, 1, 1);
        add(1, 1, 43,   1, 3, 43, 0,  0,  43, 43, 1, 1);
        // new frame: overflow persists
        add(0, 0, 0,    0, 0, 0,  0,  0,  0,  0,  0, 1);
        add(1, 1, 50,   1, 0, 50, 0,  0,  50, 50, 0, 1);
        add(1, 1, 51,   1, 1, 51, 0,  0,  51, 51, 0, 1);
        add(1, 0, 0,    0, 0, 0,  0,  0,  0,  0,  0, 1);
        add(1, 1, 60,   1, 0, 60, 50, 0,  50, 50, 0, 1);
        add(1, 1, 61,   1, 1, 61, 51, 0,  51, 51, 0, 1);
        // fsync and rsync fall together: abort
        add(0, 0, 0,    0, 0, 0,  0,  0,  0,  0,  0, 1);
        add(1, 1, 70,   1, 0, 70, 0,  0,  70, 70, 0, 1);
        add(1, 0, 0,    0, 0, 0,  0,  0,  0,  0,  0, 1);
        add(1, 1, 80,   1, 0, 80, 70, 0,  70, 70, 0, 1);
        add(1, 0, 0,    0, 0, 0,  0,  0,  0,  0,  1, 1);

        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < tv.size(); i++) begin
            fs = tv[i].fs;
            rs = tv[i].rs;
            pd = 8'(tv[i].pd);
            @(negedge clk);
            chk($sformatf("v%0d vld bm0", i), {31'd0, if0.tap_valid},   {31'd0, tv[i].vld});
            chk($sformatf("v%0d vld bm1", i), {31'd0, if1.tap_valid},   {31'd0, tv[i].vld});
            chk($sformatf("v%0d rdy", i),     {31'd0, if0.lines_ready}, {31'd0, tv[i].rdy});
            chk($sformatf("v%0d ovf", i),     {31'd0, if0.overflow},    {31'd0, tv[i].ovf});
            if (tv[i].vld) begin
                chk($sformatf("v%0d col", i),     {30'd0, if0.col_out}, tv[i].col);
                chk($sformatf("v%0d t0 bm0", i),  tap(if0.taps_out, 0), tv[i].t0);
                chk($sformatf("v%0d t1 bm0", i),  tap(if0.taps_out, 1), tv[i].t1z);
                chk($sformatf("v%0d t2 bm0", i),  tap(if0.taps_out, 2), tv[i].t2z);
                chk($sformatf("v%0d t0 bm1", i),  tap(if1.taps_out, 0), tv[i].t0);
                chk($sformatf("v%0d t1 bm1", i),  tap(if1.taps_out, 1), tv[i].t1r);
                chk($sformatf("v%0d t2 bm1", i),  tap(if1.taps_out, 2), tv[i].t2r);
            end
        end

        // Mid-line asynchronous reset between clock edges.
        fs = 1'b1; rs = 1'b1; pd = 8'd90;
        @(negedge clk);
        chk("pre-reset vld", {31'd0, if0.tap_valid}, 32'd1);
        chk("pre-reset t0",  tap(if0.taps_out, 0), 32'd90);
        pd = 8'd91;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async reset");
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        pd = 8'd92;
        @(negedge clk);
        chk("post-reset vld",    {31'd0, if0.tap_valid}, 32'd1);
        chk("post-reset col",    {30'd0, if0.col_out}, 32'd0);
        chk("post-reset t0",     tap(if0.taps_out, 0), 32'd92);
        chk("post-reset t1 bm0", tap(if0.taps_out, 1), 32'd0);
        chk("post-reset t1 bm1", tap(if1.taps_out, 1), 32'd92);
        chk("post-reset rdy",    {31'd0, if0.lines_ready}, 32'd0);
        chk("post-reset ovf",    {31'd0, if0.overflow}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
